ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Shares the single-port 16x4 RAM bank between two requesters (A, B) with valid/ready request
//  and valid-only response handshakes. Round-robin arbitration, one transaction in flight,
//  sequenced through a fixed ISSUE/WAIT/RESP pipeline. Sits between the requesters and the RAM bank;
//  drives the bank's we/addr/din and samples its dout. Also drives reading/writing status flags.
// PARAMETERS
//  ADDR_WIDTH    4  RAM address width (bank depth = 2**ADDR_WIDTH)
//  DATA_WIDTH    4  RAM data width
//  READ_LATENCY  1  cycles from RAM address sample to valid dout (>=1); sets WAIT length
// PORTS
//  clock        in   1    single clock; all state changes on rising edge
//  reset_n      in   1    asynchronous, active-low reset
//  a_req_valid  in   1    requester A has a request
//  a_req_write  in   1    1 = write, 0 = read
//  a_req_addr   in   AW   request address
//  a_req_data   in   DW   write data (ignored on read)
//  a_req_ready  out  1    A's request accepted this cycle
//  a_rsp_valid  out  1    one-cycle pulse: A's transaction complete
//  a_rsp_data   out  DW   read data / echoed write data; valid with a_rsp_valid
//  b_req_*, b_rsp_*       identical set for requester B
//  ram_we       out  1    RAM write enable
//  ram_addr     out  AW   RAM address
//  ram_din      out  DW   RAM write data
//  ram_dout     in   DW   RAM read data
//  reading      out  1    1 when the arbiter is not writing the RAM
//  writing      out  1    1 exactly when ram_we = 1 (reading = ~writing)
//  busy         out  1    1 in any state other than IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, rr_ptr=A, ram_we=0, ram_addr=0, ram_din=0,
//   a/b_rsp_valid=0, a/b_rsp_data=0, writing=0, reading=1, busy=0. Takes effect immediately,
//   even mid-transaction; an interrupted transaction is dropped and produces no response.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: grant computed combinationally. x_req_ready=1 only for the winner, only in IDLE.
//    On the accepting edge: register write flag, addr, data and owner; go to ISSUE.
//    No valid request: stay in IDLE.
//   ISSUE (1 cycle): ram_addr/ram_din come from registers. ram_we = writing = stored write flag.
//    Outside ISSUE, ram_we=0.
//   WAIT (READ_LATENCY cycles, down-counter): ram_addr is held.
//    On the last WAIT edge: capture ram_dout for reads, or the stored write data for writes,
//    into the owner's rsp_data register.
//   RESP (1 cycle): owner's rsp_valid=1; the other requester's rsp_valid=0. Then go to IDLE.
//  Latency: accept edge at cycle T -> ISSUE T+1 -> rsp_valid in T+2+READ_LATENCY.
//   Max throughput is one transaction per 3+READ_LATENCY cycles.
//  Arbitration:
//   Only one valid: it wins, regardless of rr_ptr.
//   Both valid: rr_ptr side wins.
//   rr_ptr updates on accept, to the side that was not granted.
//  Requester rules: x_req_* may change freely while x_req_ready=0. After acceptance they are
//   don't-care. A requester may re-raise valid in the RESP cycle; it is arbitrated in the next IDLE.
//  rsp_data holds its value until the next response to the same requester.
//  Same-address write then read, any requesters: the read returns the newly written data.
// STRUCTURE
//  Shared package ram_arb_pkg: state encoding (IDLE, ISSUE, WAIT, RESP), requester id constants
//   (REQ_A=0, REQ_B=1), default width/latency localparams.
//  Sub-module ram_rr_grant: 2-way round-robin grant logic. Inputs: valid[1:0], ptr, accept.
//   Outputs: grant[1:0], next ptr. Grant is combinational; the pointer is registered.
//  Top level: FSM, WAIT counter, request registers, response registers.
//  The RAM bank is instantiated by the parent, not inside this block.
// TESTING
//  1. Only A writes addr 3 data 0xA -> a_req_ready in the same cycle. ram_we=1 for exactly one cycle
//     with addr 3. a_rsp_valid pulse at T+3 (READ_LATENCY=1) with a_rsp_data=0xA.
//  2. B reads addr 3 after test 1 -> b_rsp_valid at T+3 with b_rsp_data=0xA.
//     a_rsp_valid stays 0; ram_we stays 0.
//  3. A and B both valid out of reset -> A granted first. B is granted in the next IDLE.
//     Both held valid continuously -> grants alternate A,B,A,B.
//  4. reset_n=0 during WAIT of a read -> busy=0, ram_we=0 and rsp_valid=0 immediately.
//     No response after release. The next request is serviced normally and rr_ptr=A.
//  5. Write all 16 addrs with ~addr, then read all back -> every read returns ~addr (4-bit).
//     busy is never low between back-to-back requests except in IDLE.
//  6. READ_LATENCY=3 build: read of a preloaded addr -> rsp_valid at T+5; reading=1 throughout.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arb_pkg : shared types and defaults for the RAM access arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int DEF_ADDR_WIDTH   = 4;
  localparam int DEF_DATA_WIDTH   = 4;
  localparam int DEF_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rr_grant.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_rr_grant : 2-way round-robin grant and next-pointer computation
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_rr_grant
  import ram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    ptr,
  input  logic       accept,
  output logic [1:0] grant,
  output req_id_t    ptr_next
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == REQ_A) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves to the side that lost (or was absent) on every accept.
  always_comb begin
    ptr_next = ptr;
    if (accept && (grant != 2'b00)) begin
      ptr_next = grant[0] ? other_req(REQ_A) : other_req(REQ_B);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_access_arbiter : shares one single-port RAM between requesters A and B
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  a_req_valid,
  input  logic                  a_req_write,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_data,
  output logic                  a_req_ready,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  input  logic                  b_req_valid,
  input  logic                  b_req_write,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_data,
  output logic                  b_req_ready,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  reading,
  output logic                  writing,
  output logic                  busy
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  arb_state_t            state_q, state_d;
  req_id_t               rr_ptr_q, rr_ptr_d;
  req_id_t               owner_q, owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  a_rsp_valid_q, a_rsp_valid_d;
  logic                  b_rsp_valid_q, b_rsp_valid_d;
  logic [DATA_WIDTH-1:0] a_rsp_data_q, a_rsp_data_d;
  logic [DATA_WIDTH-1:0] b_rsp_data_q, b_rsp_data_d;
  logic                  busy_q, busy_d;

  logic [1:0]            req_valid;
  logic [1:0]            grant;
  logic                  accept;
  logic                  sel_b;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] rsp_value;

  assign req_valid = {b_req_valid, a_req_valid};
  assign accept    = (state_q == IDLE) && (grant != 2'b00);
  assign sel_b     = grant[1];
  assign sel_write = sel_b ? b_req_write : a_req_write;
  assign rsp_value = wr_q ? ram_din_q : ram_dout;

  ram_rr_grant u_rr_grant (
    .valid    (req_valid),
    .ptr      (rr_ptr_q),
    .accept   (accept),
    .grant    (grant),
    .ptr_next (rr_ptr_d)
  );

  assign a_req_ready = (state_q == IDLE) && grant[0];
  assign b_req_ready = (state_q == IDLE) && grant[1];

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    a_rsp_data_d  = a_rsp_data_q;
    b_rsp_data_d  = b_rsp_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = ISSUE;
          owner_d    = sel_b ? REQ_B : REQ_A;
          wr_d       = sel_write;
          ram_we_d   = sel_write;
          ram_addr_d = sel_b ? b_req_addr : a_req_addr;
          ram_din_d  = sel_b ? b_req_data : a_req_data;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(READ_LATENCY - 1);
      end
      WAIT: begin
        // The RAM sampled the address on the ISSUE edge; dout is valid now.
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == REQ_A) begin
            a_rsp_valid_d = 1'b1;
            a_rsp_data_d  = rsp_value;
          end else begin
            b_rsp_valid_d = 1'b1;
            b_rsp_data_d  = rsp_value;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= REQ_A;
      owner_q       <= REQ_A;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_data_q  <= b_rsp_data_d;
      busy_q        <= busy_d;
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign writing     = ram_we_q;
  assign reading     = ~ram_we_q;
  assign busy        = busy_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_data  = a_rsp_data_q;
  assign b_rsp_data  = b_rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ram_access_arbiter : randomized bench with a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ram_access_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int RL = 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [DW-1:0] a_rsp_data, b_rsp_data;
  logic          ram_we, reading, writing, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [1:0]    pend;
  logic          rq_wr   [2];
  logic [AW-1:0] rq_addr [2];
  logic [DW-1:0] rq_data [2];

  ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_req_valid (pend[0]),
    .a_req_write (rq_wr[0]),
    .a_req_addr  (rq_addr[0]),
    .a_req_data  (rq_data[0]),
    .a_req_ready (a_req_ready),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_data  (a_rsp_data),
    .b_req_valid (pend[1]),
    .b_req_write (rq_wr[1]),
    .b_req_addr  (rq_addr[1]),
    .b_req_data  (rq_data[1]),
    .b_req_ready (b_req_ready),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_data  (b_rsp_data),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .reading     (reading),
    .writing     (writing),
    .busy        (busy)
  );

  // Synchronous RAM bank with RL cycles of read latency.
  logic [DW-1:0] ram_mem  [2**AW];
  logic [DW-1:0] ram_pipe [RL];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_pipe[0] <= ram_mem[ram_addr];
    for (int k = 1; k < RL; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign ram_dout = ram_pipe[RL-1];

  // Reference model state: transaction timing is relative to the accept cycle.
  req_t          qa[$];
  req_t          qb[$];
  logic [DW-1:0] mdl_mem [2**AW];
  logic [DW-1:0] shown   [2];
  int            rr;
  int            cyc;
  int            acc_cycle;
  int            acc_owner;
  logic          acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_rsp;
  int            clr_w;
  int            n_checks;
  int            n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_t r;
    r.wr   = wr;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)));
  endfunction

  function automatic bit model_idle();
    return (cyc - acc_cycle) >= (3 + RL);
  endfunction

  task automatic step();
    int   d;
    int   w;
    bit   idle;
    req_t r;
    @(negedge clock);
    if (clr_w >= 0) pend[clr_w] = 1'b0;
    clr_w = -1;
    if (!pend[0] && qa.size() > 0) begin
      r = qa.pop_front();
      pend[0] = 1'b1; rq_wr[0] = r.wr; rq_addr[0] = r.addr; rq_data[0] = r.data;
    end
    if (!pend[1] && qb.size() > 0) begin
      r = qb.pop_front();
      pend[1] = 1'b1; rq_wr[1] = r.wr; rq_addr[1] = r.addr; rq_data[1] = r.data;
    end
    #1;
    d    = cyc - acc_cycle;
    idle = model_idle();
    if (d == 2 + RL) shown[acc_owner] = acc_rsp;
    chk("busy",        32'(busy),        32'(!idle));
    chk("ram_we",      32'(ram_we),      32'(d == 1 && acc_wr));
    chk("writing",     32'(writing),     32'(d == 1 && acc_wr));
    chk("reading",     32'(reading),     32'(!(d == 1 && acc_wr)));
    if (d >= 1 && d <= 1 + RL) chk("ram_addr", 32'(ram_addr), 32'(acc_addr));
    chk("a_rsp_valid", 32'(a_rsp_valid), 32'(d == 2 + RL && acc_owner == 0));
    chk("b_rsp_valid", 32'(b_rsp_valid), 32'(d == 2 + RL && acc_owner == 1));
    chk("a_rsp_data",  32'(a_rsp_data),  32'(shown[0]));
    chk("b_rsp_data",  32'(b_rsp_data),  32'(shown[1]));
    w = -1;
    if (idle) begin
      if (pend[0] && pend[1]) w = rr;
      else if (pend[0])       w = 0;
      else if (pend[1])       w = 1;
    end
    chk("a_req_ready", 32'(a_req_ready), 32'(w == 0));
    chk("b_req_ready", 32'(b_req_ready), 32'(w == 1));
    @(posedge clock);
    if (w >= 0) begin
      acc_cycle = cyc;
      acc_owner = w;
      acc_wr    = rq_wr[w];
      acc_addr  = rq_addr[w];
      acc_rsp   = rq_wr[w] ? rq_data[w] : mdl_mem[rq_addr[w]];
      if (rq_wr[w]) mdl_mem[rq_addr[w]] = rq_data[w];
      rr    = 1 - w;
      clr_w = w;
    end
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || pend != 2'b00 || clr_w >= 0 || !model_idle()) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic model_reset();
    acc_cycle = -1000;
    acc_owner = 0;
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_rsp   = '0;
    rr        = 0;
    shown[0]  = '0;
    shown[1]  = '0;
    pend      = 2'b00;
    clr_w     = -1;
    qa.delete();
    qb.delete();
  endtask

  task automatic reset_mid_read();
    bit got;
    got = 1'b0;
    qa.push_back(mk(1'b0, 4'd5, 4'd0));
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (acc_cycle == cyc - 1) got = 1'b1;
    end
    if (!got) chk("reset_accept_timeout", 32'd0, 32'd1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_we",     32'(ram_we),      32'd0);
    chk("rst_a_rsp",  32'(a_rsp_valid), 32'd0);
    chk("rst_b_rsp",  32'(b_rsp_valid), 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    for (int i = 0; i < 2**AW; i++) mdl_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      rq_wr[i] = 1'b0; rq_addr[i] = '0; rq_data[i] = '0;
    end
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_busy",    32'(busy),        32'd0);
    chk("reset_reading", 32'(reading),     32'd1);
    chk("reset_writing", 32'(writing),     32'd0);
    chk("reset_addr",    32'(ram_addr),    32'd0);
    chk("reset_din",     32'(ram_din),     32'd0);
    chk("reset_a_rsp",   32'(a_rsp_valid), 32'd0);
    reset_n = 1'b1;

    // Simultaneous A write / B read of the same address: A wins, B sees new data.
    qa.push_back(mk(1'b1, 4'd3, 4'hA));
    qb.push_back(mk(1'b0, 4'd3, 4'h0));
    drain();
    chk("t1_a_data", 32'(a_rsp_data), 32'hA);
    chk("t2_b_data", 32'(b_rsp_data), 32'hA);

    // Both held valid: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(1'b1, AW'($urandom_range(0, 15)), DW'($urandom_range(0, 15))));
      qb.push_back(mk(1'b1, AW'($urandom_range(0, 15)), DW'($urandom_range(0, 15))));
    end
    drain();

    reset_mid_read();
    repeat (6) step();
    qb.push_back(mk(1'b0, 4'd3, 4'h0));
    qa.push_back(mk(1'b1, 4'd7, 4'h6));
    drain();

    // Full sweep: write ~addr everywhere, read it all back from B.
    for (int a = 0; a < 2**AW; a++) qa.push_back(mk(1'b1, AW'(a), ~DW'(a)));
    drain();
    for (int a = 0; a < 2**AW; a++) qb.push_back(mk(1'b0, AW'(a), 4'h0));
    drain();
    chk("sweep_last", 32'(b_rsp_data), 32'h0);

    for (int i = 0; i < 1500; i++) begin
      if (qa.size() < 2 && $urandom_range(0, 2) == 0) qa.push_back(rnd_req());
      if (qb.size() < 2 && $urandom_range(0, 2) == 0) qb.push_back(rnd_req());
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
